// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: FSM states, status bytes,
// instruction memory word-index width and the word-index to byte-address map.
package instr_loader_pkg;

  localparam int unsigned MEM_ADDR_W = 13;
  localparam logic [7:0]  ACK_BYTE   = 8'hAA;
  localparam logic [7:0]  NAK_BYTE   = 8'hEE;

  typedef enum logic [2:0] {
    ST_LEN,
    ST_DATA,
    ST_ACK,
    ST_ERR_TX,
    ST_LOADED,
    ST_ERROR
  } state_t;

  // Byte address of a word slot in the instruction memory.
  function automatic logic [31:0] word_addr(input logic [MEM_ADDR_W-1:0] idx);
    return {{(32 - MEM_ADDR_W - 2){1'b0}}, idx, 2'b00};
  endfunction

endpackage

// File: rtl/instr_loader_byte_word_assembler.sv
// Collects four consecutive bytes into a little-endian 32-bit word.
// The completed word and its strobe are presented combinationally in the
// cycle the fourth byte arrives, so the caller can register them directly.
module instr_loader_byte_word_assembler (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [1:0]  byte_cnt,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [31:0] shreg;

  // Byte position counter and shift register; newest byte enters at the top.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_cnt <= '0;
      shreg    <= '0;
    end else if (clr) begin
      byte_cnt <= '0;
      shreg    <= '0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 2'd1;
      shreg    <= {byte_in, shreg[31:8]};
    end
  end

  // Complete word: first byte of the group ends up in [7:0].
  always_comb begin
    word       = {byte_in, shreg[31:8]};
    word_valid = byte_valid && (byte_cnt == 2'd3);
  end

endmodule

// File: rtl/instr_loader.sv
// Program loader: receives a length-prefixed little-endian word stream from
// the UART, writes it into the instruction memory through its I/O port, then
// hands the memory to the processor and reports a status byte to the host.
module instr_loader #(
  parameter int unsigned DEPTH_WORDS = 8192,
  parameter logic [7:0]  ACK_BYTE    = instr_loader_pkg::ACK_BYTE,
  parameter logic [7:0]  NAK_BYTE    = instr_loader_pkg::NAK_BYTE
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        load_req,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        io_sel,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        loaded,
  output logic        error
);

  import instr_loader_pkg::*;

  state_t                 state;
  logic [31:0]            len;
  logic [MEM_ADDR_W-1:0]  word_idx;

  logic                   asm_valid;
  logic                   asm_clr;
  logic [1:0]             byte_cnt;
  logic [31:0]            asm_word;
  logic                   word_valid;
  logic [31:0]            full_len;
  logic                   last_word;

  // Bytes are only consumed while receiving the length or the payload; a
  // restart clears any partial group.
  always_comb begin
    asm_valid = rx_valid && ((state == ST_LEN) || (state == ST_DATA));
    asm_clr   = load_req && ((state == ST_LOADED) || (state == ST_ERROR));
    full_len  = {rx_data, len[23:0]};
    last_word = ({{(32 - MEM_ADDR_W){1'b0}}, word_idx} == (len - 32'd1));
  end

  instr_loader_byte_word_assembler u_asm (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (asm_clr),
    .byte_valid (asm_valid),
    .byte_in    (rx_data),
    .byte_cnt   (byte_cnt),
    .word       (asm_word),
    .word_valid (word_valid)
  );

  // Load sequencing FSM with registered memory, status and UART outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_LEN;
      io_sel   <= 1'b1;
      mem_we   <= 1'b0;
      mem_en   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      loaded   <= 1'b0;
      error    <= 1'b0;
      word_idx <= '0;
      len      <= '0;
    end else begin
      mem_we <= 1'b0;
      mem_en <= 1'b0;
      unique case (state)
        ST_LEN: begin
          if (rx_valid) begin
            len[8*byte_cnt +: 8] <= rx_data;
            // Decide on the complete count including the byte arriving now.
            if (word_valid) begin
              if (full_len == '0) begin
                state    <= ST_ACK;
                tx_valid <= 1'b1;
                tx_data  <= ACK_BYTE;
              end else if (full_len > DEPTH_WORDS) begin
                state    <= ST_ERR_TX;
                tx_valid <= 1'b1;
                tx_data  <= NAK_BYTE;
              end else begin
                state <= ST_DATA;
              end
            end
          end
        end
        ST_DATA: begin
          if (word_valid) begin
            mem_din  <= asm_word;
            mem_addr <= word_addr(word_idx);
            mem_we   <= 1'b1;
            mem_en   <= 1'b1;
            word_idx <= word_idx + 1'b1;
            if (last_word) state <= ST_ACK;
          end
        end
        ST_ACK: begin
          // Entered from DATA with tx idle: raise the status one cycle after
          // the final write strobe.
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= ACK_BYTE;
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
            loaded   <= 1'b1;
            io_sel   <= 1'b0;
            state    <= ST_LOADED;
          end
        end
        ST_ERR_TX: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            error    <= 1'b1;
            state    <= ST_ERROR;
          end
        end
        ST_LOADED, ST_ERROR: begin
          if (load_req) begin
            state    <= ST_LEN;
            loaded   <= 1'b0;
            error    <= 1'b0;
            io_sel   <= 1'b1;
            word_idx <= '0;
            len      <= '0;
          end
        end
        default: state <= ST_LEN;
      endcase
    end
  end

endmodule
